// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects and extends write-back data and counts captured instructions.
// Optional sub-word load extension is enabled by defining SUBWORD_LOAD_EN.
module mem_wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_rfwr,
   input  logic [4:0]  mem_a3,
   input  logic [1:0]  mem_wdsel,
   input  logic [31:0] mem_alu,
   input  logic [31:0] mem_rdata,
   input  logic [31:0] mem_pc,
   input  logic [2:0]  mem_dmtype,
   input  logic [1:0]  mem_byteoff,
   input  logic        stall,
   input  logic        flush,
   output logic        RFWr,
   output logic [4:0]  A3,
   output logic [31:0] WD,
   output logic        wb_valid,
   output logic [31:0] retired_cnt
);

   typedef enum logic [2:0] {
      DM_LW  = 3'b000,
      DM_LH  = 3'b001,
      DM_LHU = 3'b010,
      DM_LB  = 3'b011,
      DM_LBU = 3'b100
   } dmtype_e;

   typedef enum logic [1:0] {
      WD_ALU  = 2'b00,
      WD_LOAD = 2'b01,
      WD_PC4  = 2'b10
   } wdsel_e;

   logic [31:0] load_data;
   logic [31:0] wd_next;

`ifdef SUBWORD_LOAD_EN
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = mem_rdata[8*mem_byteoff +: 8];
   // Halfword loads are aligned on bit 1 only; a set bit 0 is ignored.
   assign half_sel = mem_byteoff[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      // NOTE: default first, so every path assigns load_data and no latch is inferred.
      load_data = mem_rdata;
      case (dmtype_e'(mem_dmtype))
         DM_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         DM_LHU:  load_data = {16'h0000, half_sel};
         DM_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         DM_LBU:  load_data = {24'h000000, byte_sel};
         default: load_data = mem_rdata;
      endcase
   end
`else
   logic unused_subword;

   assign unused_subword = ^{mem_dmtype, mem_byteoff};
   assign load_data      = mem_rdata;
`endif

   always_comb begin
      wd_next = mem_alu;
      case (wdsel_e'(mem_wdsel))
         WD_LOAD: wd_next = load_data;
         WD_PC4:  wd_next = mem_pc + 32'd4;
         default: wd_next = mem_alu;
      endcase
   end

   // Flush outranks stall; a flushed slot keeps A3/WD but can never write the register file.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         RFWr        <= 1'b0;
         A3          <= 5'd0;
         WD          <= 32'd0;
         wb_valid    <= 1'b0;
         retired_cnt <= 32'd0;
      end else if (flush) begin
         RFWr     <= 1'b0;
         wb_valid <= 1'b0;
      end else if (!stall) begin
         RFWr     <= mem_valid & mem_rfwr & (mem_a3 != 5'd0);
         A3       <= mem_a3;
         WD       <= wd_next;
         wb_valid <= mem_valid;
         if (mem_valid)
            retired_cnt <= retired_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected WB state is queued when MEM inputs are driven
// and compared one clock later; load expectations follow SUBWORD_LOAD_EN.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic        mem_rfwr;
   logic [4:0]  mem_a3;
   logic [1:0]  mem_wdsel;
   logic [31:0] mem_alu;
   logic [31:0] mem_rdata;
   logic [31:0] mem_pc;
   logic [2:0]  mem_dmtype;
   logic [1:0]  mem_byteoff;
   logic        stall;
   logic        flush;
   logic        RFWr;
   logic [4:0]  A3;
   logic [31:0] WD;
   logic        wb_valid;
   logic [31:0] retired_cnt;

   mem_wb_stage dut (
      .clk         (clk),
      .rst         (rst),
      .mem_valid   (mem_valid),
      .mem_rfwr    (mem_rfwr),
      .mem_a3      (mem_a3),
      .mem_wdsel   (mem_wdsel),
      .mem_alu     (mem_alu),
      .mem_rdata   (mem_rdata),
      .mem_pc      (mem_pc),
      .mem_dmtype  (mem_dmtype),
      .mem_byteoff (mem_byteoff),
      .stall       (stall),
      .flush       (flush),
      .RFWr        (RFWr),
      .A3          (A3),
      .WD          (WD),
      .wb_valid    (wb_valid),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rfwr;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic        valid;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_errors = 0;
   bit have_state = 1'b0;

   // Reference model of the WB registers
   logic        m_rfwr  = 1'b0;
   logic [4:0]  m_a3    = 5'd0;
   logic [31:0] m_wd    = 32'd0;
   logic        m_valid = 1'b0;
   logic [31:0] m_cnt   = 32'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [2:0] dt,
                                              input logic [1:0] off);
      logic [31:0] result;
`ifdef SUBWORD_LOAD_EN
      logic [31:0] bsh;
      logic [31:0] hsh;
      bsh = rdata >> (8 * off);
      hsh = rdata >> (16 * off[1]);
      case (dt)
         3'd1:    result = 32'($signed(hsh[15:0]));
         3'd2:    result = hsh & 32'h0000FFFF;
         3'd3:    result = 32'($signed(bsh[7:0]));
         3'd4:    result = bsh & 32'h000000FF;
         default: result = rdata;
      endcase
`else
      result = rdata ^ 32'(dt & 3'd0) ^ 32'(off & 2'd0);
`endif
      return result;
   endfunction

   task automatic step(input logic r, input logic v, input logic rf, input logic [4:0] a3,
                       input logic [1:0] ws, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] pc, input logic [2:0] dt, input logic [1:0] off,
                       input logic st, input logic fl);
      exp_t e;
      @(negedge clk);
      if (have_state) begin
         check("wd_at_negedge", WD, m_wd);
         check("rfwr_at_negedge", {31'd0, RFWr}, {31'd0, m_rfwr});
      end
      rst = r; mem_valid = v; mem_rfwr = rf; mem_a3 = a3; mem_wdsel = ws;
      mem_alu = alu; mem_rdata = rd; mem_pc = pc; mem_dmtype = dt; mem_byteoff = off;
      stall = st; flush = fl;
      if (r) begin
         m_rfwr = 1'b0; m_a3 = 5'd0; m_wd = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
      end else if (fl) begin
         m_rfwr = 1'b0; m_valid = 1'b0;
      end else if (!st) begin
         m_valid = v;
         m_rfwr  = v && rf && (a3 != 5'd0);
         m_a3    = a3;
         if (ws == 2'b01)      m_wd = model_load(rd, dt, off);
         else if (ws == 2'b10) m_wd = pc + 32'd4;
         else                  m_wd = alu;
         if (v) m_cnt = m_cnt + 32'd1;
      end
      e = '{rfwr: m_rfwr, a3: m_a3, wd: m_wd, valid: m_valid, cnt: m_cnt};
      sb.push_back(e);
      @(posedge clk);
      #1;
      have_state = 1'b1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("RFWr",        {31'd0, RFWr},     {31'd0, e.rfwr});
         check("A3",          {27'd0, A3},       {27'd0, e.a3});
         check("WD",          WD,                e.wd);
         check("wb_valid",    {31'd0, wb_valid}, {31'd0, e.valid});
         check("retired_cnt", retired_cnt,       e.cnt);
      end
   endtask

   task automatic load(input logic [2:0] dt, input logic [1:0] off);
      step(1'b0, 1'b1, 1'b1, 5'd9, 2'b01, 32'hDEADBEEF, 32'h80F1_7F02, 32'h100, dt, off, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; mem_valid = 1'b0; mem_rfwr = 1'b0; mem_a3 = 5'd0; mem_wdsel = 2'b00;
      mem_alu = 32'd0; mem_rdata = 32'd0; mem_pc = 32'd0; mem_dmtype = 3'd0;
      mem_byteoff = 2'd0; stall = 1'b0; flush = 1'b0;

      // Reset with random inputs
      repeat (2)
         step(1'b1, 1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), $urandom,
              $urandom, $urandom, 3'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));

      // ALU write
      step(1'b0, 1'b1, 1'b1, 5'd5, 2'b00, 32'h12345678, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);

      // Loads from 0x80F17F02
      load(3'd3, 2'd3);
      load(3'd4, 2'd3);
      load(3'd1, 2'd2);
      load(3'd2, 2'd1);
      load(3'd0, 2'd1);
      load(3'd3, 2'd0);
      load(3'd1, 2'd3);
      load(3'd7, 2'd2);

      // r0 destination, then link with PC wrap
      step(1'b0, 1'b1, 1'b1, 5'd0, 2'b00, 32'hAAAA5555, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd1, 2'b10, 32'h11111111, 32'h0, 32'hFFFFFFFC, 3'd0, 2'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd2, 2'b11, 32'h0BADCAFE, 32'h1, 32'h2, 3'd0, 2'd0, 1'b0, 1'b0);

      // Stall for three cycles with changing inputs
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 1'b1, 5'(i + 7), 2'b00, $urandom, $urandom, $urandom, 3'd0, 2'd0, 1'b1, 1'b0);

      // Stall and flush together, then a capture
      step(1'b0, 1'b1, 1'b1, 5'd12, 2'b00, 32'h5A5A5A5A, 32'h0, 32'h0, 3'd0, 2'd0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 5'd13, 2'b00, 32'hC0FFEE00, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 5'd14, 2'b00, 32'h0000BEEF, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 5'd15, 2'b00, 32'h00000001, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);

      // Reset during a stall discards the held write
      step(1'b0, 1'b1, 1'b1, 5'd20, 2'b00, 32'h77777777, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd21, 2'b00, 32'h88888888, 32'h0, 32'h0, 3'd0, 2'd0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 5'd22, 2'b00, 32'h99999999, 32'h0, 32'h0, 3'd0, 2'd0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 5'd23, 2'b00, 32'hAAAAAAAA, 32'h0, 32'h0, 3'd0, 2'd0, 1'b1, 1'b0);

      // Counter wrap
      force dut.retired_cnt = 32'hFFFFFFFF;
      #1;
      release dut.retired_cnt;
      m_cnt = 32'hFFFFFFFF;
      step(1'b0, 1'b1, 1'b0, 5'd3, 2'b00, 32'h00000042, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 5'd4, 2'b00, 32'h00000043, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);

      // Random traffic
      for (int i = 0; i < 80; i++)
         step(1'($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 5'($urandom),
              2'($urandom), $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)),
              2'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));

      if (sb.size() != 0)
         check("scoreboard_leftover", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
